// File: rtl/adc_chan_avg_if.sv
// Sample-bus / averaged-bus bundle between the LTC2308 controller, the
// channel averager and its consumer.
interface adc_chan_avg_if #(
  parameter int NUM_CH = 2
);
  logic                   adc_sync;
  logic [NUM_CH*12-1:0]   adc_data;
  logic [11:0]            thr_low;
  logic [11:0]            thr_high;
  logic [NUM_CH*12-1:0]   avg_data;
  logic                   avg_sync;
  logic                   avg_valid;
  logic                   overrun;
  logic [NUM_CH-1:0]      hyst;

  modport master (
    output adc_sync, adc_data, thr_low, thr_high,
    input  avg_data, avg_sync, avg_valid, overrun, hyst
  );

  modport slave (
    input  adc_sync, adc_data, thr_low, thr_high,
    output avg_data, avg_sync, avg_valid, overrun, hyst
  );
endinterface

// File: rtl/adc_chan_avg.sv
// Serial boxcar averager over 2^AVG_LOG2 ADC rounds with coherent publish.
// Optional per-channel hysteresis comparator: define ADC_AVG_HYST_EN.
module adc_chan_avg #(
  parameter int NUM_CH   = 2,
  parameter int AVG_LOG2 = 2
) (
  input  logic           clk,
  input  logic           reset,
  adc_chan_avg_if.slave  bus
);
  localparam int AW = 12 + AVG_LOG2;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [RW-1:0] RND_LAST = RW'((1 << AVG_LOG2) - 1);
  localparam logic [CW-1:0] CH_LAST  = CW'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  state_t r_state, w_next;

  logic                           r_sync_s, r_sync_d, r_primed;
  logic [NUM_CH-1:0][11:0]        r_snap;
  logic [NUM_CH-1:0][AW-1:0]      r_acc;
  logic [NUM_CH-1:0][11:0]        r_stage;
  logic [NUM_CH-1:0][11:0]        r_avg;
  logic                           r_avg_sync, r_avg_valid, r_overrun;
  logic [NUM_CH-1:0]              r_hyst;
  logic [CW-1:0]                  r_ch;
  logic [RW-1:0]                  r_rnd;

  logic                           w_event, w_last;
  logic [AW-1:0]                  w_sum, w_quot;
  logic [NUM_CH-1:0]              w_hyst_nxt;

  // Input is registered once so the snapshot lands one edge after sampling;
  // until primed, the delay stage loads straight from the pin so a level held
  // through reset release never looks like a toggle.
  assign w_event = r_primed & (r_sync_s ^ r_sync_d);
  assign w_last  = (r_rnd == RND_LAST);
  assign w_sum   = ((r_rnd == '0) ? '0 : r_acc[r_ch]) + AW'(r_snap[r_ch]);
  assign w_quot  = w_sum >> AVG_LOG2;

`ifdef ADC_AVG_HYST_EN
  always_comb begin
    w_hyst_nxt = r_hyst;
    for (int i = 0; i < NUM_CH; i++) begin
      if (r_stage[i] < bus.thr_low)       w_hyst_nxt[i] = 1'b0;
      else if (r_stage[i] > bus.thr_high) w_hyst_nxt[i] = 1'b1;
    end
  end
`else
  logic w_unused_thr;
  assign w_unused_thr = ^{bus.thr_low, bus.thr_high};
  assign w_hyst_nxt   = '0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_event) w_next = S_ACCUM;
      S_ACCUM: if (r_ch == CH_LAST) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync_s    <= 1'b0;
      r_sync_d    <= 1'b0;
      r_primed    <= 1'b0;
      r_snap      <= '0;
      r_acc       <= '0;
      r_stage     <= '0;
      r_avg       <= '0;
      r_avg_sync  <= 1'b0;
      r_avg_valid <= 1'b0;
      r_overrun   <= 1'b0;
      r_hyst      <= '0;
      r_ch        <= '0;
      r_rnd       <= '0;
    end else begin
      r_sync_s    <= bus.adc_sync;
      r_sync_d    <= r_primed ? r_sync_s : bus.adc_sync;
      r_primed    <= 1'b1;
      r_avg_valid <= 1'b0;
      if (w_event && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_event) begin
            r_snap <= bus.adc_data;
            r_ch   <= '0;
          end
        end
        S_ACCUM: begin
          r_acc[r_ch] <= w_sum;
          if (w_last) r_stage[r_ch] <= w_quot[11:0];
          if (r_ch != CH_LAST) r_ch <= r_ch + CW'(1);
        end
        S_DONE: begin
          if (w_last) begin
            r_avg       <= r_stage;
            r_avg_sync  <= ~r_avg_sync;
            r_avg_valid <= 1'b1;
            r_hyst      <= w_hyst_nxt;
            r_rnd       <= '0;
          end else begin
            r_rnd       <= r_rnd + RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.avg_data  = r_avg;
  assign bus.avg_sync  = r_avg_sync;
  assign bus.avg_valid = r_avg_valid;
  assign bus.overrun   = r_overrun;
  assign bus.hyst      = r_hyst;
endmodule

// File: tb/tb_adc_chan_avg.sv
// Directed bench: table of ADC rounds for a 2ch/4-round averager, plus
// hand sequences for passthrough latency, overrun and mid-accumulate reset.
module tb_adc_chan_avg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_chan_avg_if #(.NUM_CH(2)) if0 ();
  adc_chan_avg_if #(.NUM_CH(3)) if1 ();

  adc_chan_avg #(.NUM_CH(2), .AVG_LOG2(2)) dut0 (.clk(clk), .reset(rst), .bus(if0));
  adc_chan_avg #(.NUM_CH(3), .AVG_LOG2(0)) dut1 (.clk(clk), .reset(rst), .bus(if1));

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int d0; int d1;
    int vcnt;
    int e0; int e1; int esync; int ehyst;
  } vec_t;

  vec_t tbl[12];

  function automatic int hx(input int v);
`ifdef ADC_AVG_HYST_EN
    return v;
`else
    return 0 * v;
`endif
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One ADC round on dut0: present data, toggle sync, watch 8 edges.
  task automatic do_round(input int d0, input int d1, output int vcnt, output int vk);
    @(negedge clk);
    if0.adc_data = {12'(d1), 12'(d0)};
    if0.adc_sync = ~if0.adc_sync;
    vcnt = 0; vk = -1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (if0.avg_valid) begin vcnt++; vk = k; end
    end
  endtask

  task automatic chk_out0(input string tag, input int e0, input int e1, input int es, input int eh);
    chk({tag, "_ch0"},  64'(if0.avg_data[11:0]),  64'(e0));
    chk({tag, "_ch1"},  64'(if0.avg_data[23:12]), 64'(e1));
    chk({tag, "_sync"}, 64'(if0.avg_sync),        64'(es));
    chk({tag, "_hyst"}, 64'(if0.hyst),            64'(eh));
  endtask

  initial begin
    int vcnt, vk;
    logic [35:0] pre, post;
    int pk;

    tbl[0]  = '{100, 4095, 0,   0,    0, 0, hx(0)};
    tbl[1]  = '{200, 4095, 0,   0,    0, 0, hx(0)};
    tbl[2]  = '{300, 4095, 0,   0,    0, 0, hx(0)};
    tbl[3]  = '{400, 4095, 1, 250, 4095, 1, hx(3)};
    tbl[4]  = '{  1,  150, 0, 250, 4095, 1, hx(3)};
    tbl[5]  = '{  1,  150, 0, 250, 4095, 1, hx(3)};
    tbl[6]  = '{  1,  150, 0, 250, 4095, 1, hx(3)};
    tbl[7]  = '{  2,  150, 1,   1,  150, 0, hx(2)};
    tbl[8]  = '{150,   50, 0,   1,  150, 0, hx(2)};
    tbl[9]  = '{150,   50, 0,   1,  150, 0, hx(2)};
    tbl[10] = '{150,   50, 0,   1,  150, 0, hx(2)};
    tbl[11] = '{150,   50, 1, 150,   50, 1, hx(0)};

    if0.adc_sync = 1'b0; if0.adc_data = '0;
    if0.thr_low = 12'd100; if0.thr_high = 12'd200;
    if1.adc_sync = 1'b0; if1.adc_data = '0;
    if1.thr_low = 12'd100; if1.thr_high = 12'd200;

    #1;
    chk_out0("rst", 0, 0, 0, 0);
    chk("rst_valid",   64'(if0.avg_valid), 64'd0);
    chk("rst_overrun", 64'(if0.overrun),   64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_round(tbl[i].d0, tbl[i].d1, vcnt, vk);
      chk($sformatf("r%0d_vcnt", i), 64'(vcnt), 64'(tbl[i].vcnt));
      if (tbl[i].vcnt == 1) chk($sformatf("r%0d_vedge", i), 64'(vk), 64'd4);
      chk_out0($sformatf("r%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].esync, tbl[i].ehyst);
    end
    chk("tbl_overrun", 64'(if0.overrun), 64'd0);

    // Passthrough, 3 channels: publish exactly at T+5, all channels together.
    @(negedge clk);
    if1.adc_data = {12'hABC, 12'h222, 12'h111};
    if1.adc_sync = ~if1.adc_sync;
    pk = -1; pre = '1; post = '0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (k == 4) pre = if1.avg_data;
      if (k == 5) post = if1.avg_data;
      if (if1.avg_valid) pk = k;
    end
    chk("pt_pre",   64'(pre),  64'd0);
    chk("pt_vedge", 64'(pk),   64'd5);
    chk("pt_data",  64'(post), 64'hABC222111);
    chk("pt_sync",  64'(if1.avg_sync), 64'd1);

    // Second toggle while busy: dropped, overrun sticks, round count intact.
    @(negedge clk);
    if0.adc_data = {12'd20, 12'd10};
    if0.adc_sync = ~if0.adc_sync;
    repeat (2) @(negedge clk);
    if0.adc_data = {12'd999, 12'd999};
    if0.adc_sync = ~if0.adc_sync;
    repeat (8) @(negedge clk);
    chk("ovr_set", 64'(if0.overrun), 64'd1);
    for (int i = 0; i < 3; i++) begin
      do_round(10, 20, vcnt, vk);
      chk($sformatf("ovr%0d_vcnt", i), 64'(vcnt), 64'(i == 2 ? 1 : 0));
    end
    chk_out0("ovr", 10, 20, 0, hx(0));
    chk("ovr_hold", 64'(if0.overrun), 64'd1);

    // Reset in the middle of accumulating round 3.
    do_round(1000, 1000, vcnt, vk);
    do_round(1000, 1000, vcnt, vk);
    @(negedge clk);
    if0.adc_data = {12'd1000, 12'd1000};
    if0.adc_sync = ~if0.adc_sync;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    if0.adc_sync = 1'b1;
    #1;
    chk_out0("mrst", 0, 0, 0, 0);
    chk("mrst_overrun", 64'(if0.overrun), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vcnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (if0.avg_valid) vcnt++;
    end
    chk("mrst_noevt", 64'(vcnt), 64'd0);
    for (int i = 0; i < 4; i++) begin
      do_round(40, 40, vcnt, vk);
      chk($sformatf("post%0d_vcnt", i), 64'(vcnt), 64'(i == 3 ? 1 : 0));
    end
    chk_out0("post", 40, 40, 1, hx(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_chan_avg.md
Name: adc_chan_avg

Overview:
- Downstream stage of the LTC2308 controller.
- Consumes the packed 12-bit-per-channel sample bus and its per-round toggle strobe.
- Boxcar-averages each channel over 2^AVG_LOG2 ADC rounds and publishes the decimated result as a coherent packed word with its own toggle strobe and a one-cycle valid pulse.
- Channels are processed serially, one per clock, so a single 12+AVG_LOG2-bit adder is shared.

Parameters:
- NUM_CH, 2, channel count 1..8; must match the upstream controller.
- AVG_LOG2, 2, log2 of rounds averaged, 0..6; 0 = passthrough with the same latency.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- adc_sync  in  1  toggles once per completed ADC round (upstream dout_sync)
- adc_data  in  NUM_CH*12  packed samples, ch i at [i*12 +: 12], unsigned
- thr_low  in  12  hysteresis low threshold (used only with ADC_AVG_HYST_EN)
- thr_high  in  12  hysteresis high threshold (used only with ADC_AVG_HYST_EN)
- avg_data  out  NUM_CH*12  averaged samples, same packing as adc_data
- avg_sync  out  1  toggles on every avg_data update
- avg_valid  out  1  one-cycle pulse on every avg_data update
- overrun  out  1  sticky: an adc_sync toggle arrived while busy
- hyst  out  NUM_CH  per-channel hysteresis comparator bit

Behaviour:
- Reset values (all asynchronous):
  - avg_data=0, avg_sync=0, avg_valid=0, overrun=0, hyst=0
  - round counter rnd=0, accumulators=0, state=IDLE
  - primed=0, adc_sync_d=0
- Edge detect:
  - adc_sync_d <= adc_sync every cycle.
  - primed <= 1 on the first clock after reset release.
  - event = primed & (adc_sync ^ adc_sync_d). The first post-reset cycle never produces an event.
- States:
  - IDLE: on event, snap <= adc_data (all channels at once), ch <= 0, go to ACCUM.
  - ACCUM: one channel per cycle.
    - rnd==0: acc[ch] <= snap[ch].
    - otherwise: acc[ch] <= acc[ch] + snap[ch].
    - On the last round (rnd == 2^AVG_LOG2-1), stage[ch] <= (acc[ch]+snap[ch]) >> AVG_LOG2. Truncating; no saturation needed because the accumulator width is 12+AVG_LOG2.
    - ch==NUM_CH-1 -> DONE; else ch <= ch+1.
  - DONE (one cycle):
    - If the last round: avg_data <= stage, avg_sync <= ~avg_sync, avg_valid <= 1 for this one cycle, rnd <= 0.
    - Otherwise: rnd <= rnd+1.
    - Return to IDLE.
- Latency: adc_sync toggle sampled on edge T -> snapshot on edge T+1 -> ACCUM on edges T+2..T+1+NUM_CH -> DONE/update on edge T+2+NUM_CH.
- Coherency: avg_data changes only in DONE, all channels in the same cycle; no partial update is ever visible.
- Busy = state != IDLE.
  - An event while busy is dropped: snap is not overwritten and the round is not counted.
  - overrun <= 1, held until reset.
- Event in the DONE cycle counts as busy (dropped).
- rnd wraps at 2^AVG_LOG2. AVG_LOG2=0: every round publishes, stage = snap.
- Reset mid-ACCUM: all state cleared immediately; the next average starts from rnd=0.
- adc_data is sampled only at snapshot; changes at other times are ignored.

Optional Feature:
- Macro: ADC_AVG_HYST_EN.
- Defined:
  - In DONE with publish, per channel: if stage[ch] < thr_low, hyst[ch] <= 0; else if stage[ch] > thr_high, hyst[ch] <= 1; else hold.
  - Thresholds are sampled in that same cycle.
  - thr_low > thr_high is legal; low test has priority.
- Undefined: hyst is held at 0; thr_low/thr_high are unused, ports remain present.

Test Plan:
- NUM_CH=2, AVG_LOG2=2; ch0 100,200,300,400, ch1 4095 x4 -> after the 4th toggle, avg_data ch0=250, ch1=4095; avg_sync 0->1; avg_valid high exactly 1 cycle at T+4.
- Same config, ch0 1,1,1,2 -> ch0=1 (truncation); no avg_valid on toggles 1-3; a second group of 4 toggles avg_sync back to 0.
- AVG_LOG2=0, NUM_CH=3, one toggle with ch2=0xABC -> ch2=0xABC at edge T+5, ch0/ch1 updated in the same cycle.
- Second adc_sync toggle 2 cycles after the first (busy) -> overrun=1 and stays 1; round count unaffected (3 further valid toggles publish).
- Reset asserted during ACCUM of round 3, then 4 toggles of 40 -> avg=40; the pre-reset partial sum must not leak. adc_sync held at 1 through reset release -> no event.
- ADC_AVG_HYST_EN, thr_low=100, thr_high=200; averages 250, 150, 50 -> hyst 1, 1, 0; without the macro, hyst stays 0.
